// File: rtl/sdram_port_arb_pkg.sv
// Shared types and helpers for the three-port SDRAM scheduler:
// FSM state encoding, port indices and the round-robin selector.
package sdram_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  localparam int unsigned NUM_PORTS = 3;

  localparam logic [1:0] PORT_WR  = 2'd0;
  localparam logic [1:0] PORT_RD0 = 2'd1;
  localparam logic [1:0] PORT_RD1 = 2'd2;

  // One-hot pick of the first eligible port after `last`, wrapping rd1 -> write.
  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = '0;
    idx  = last;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (idx == PORT_RD1) ? PORT_WR : idx + 2'd1;
      if ((pick == '0) && elig[idx]) begin
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [1:0] onehot_to_port(input logic [2:0] oh);
    logic [1:0] port;
    port = PORT_WR;
    if (oh[PORT_RD0]) port = PORT_RD0;
    if (oh[PORT_RD1]) port = PORT_RD1;
    return port;
  endfunction

endpackage

// File: rtl/sdram_port_addr.sv
// Per-port SDRAM address counter: advances by one burst per transaction with
// frame wrap, and rewinds to the port base on a (possibly deferred) frame start.
module sdram_port_addr #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned BASE      = 0,
  parameter int unsigned BURST     = 256,
  parameter int unsigned FRAME_LEN = 384000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start_i,
  input  logic              granted_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int unsigned       AW1     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   BURST_X = AW1'(BURST);
  localparam logic [ADDR_W:0]   LIMIT_X = AW1'(BASE + FRAME_LEN);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pending_q, pending_d;
  logic [ADDR_W:0]   next_x;

  always_comb begin
    next_x    = {1'b0, addr_q} + BURST_X;
    addr_d    = addr_q;
    pending_d = pending_q;
    if (advance_i) begin
      // A pulse coinciding with the end of this port's burst rewinds as well.
      pending_d = 1'b0;
      if (pending_q || frame_start_i || (next_x >= LIMIT_X)) begin
        addr_d = BASE_A;
      end else begin
        addr_d = next_x[ADDR_W-1:0];
      end
    end else begin
      if (!granted_i && pending_q) begin
        addr_d    = BASE_A;
        pending_d = 1'b0;
      end
      if (frame_start_i) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= BASE_A;
      pending_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      pending_q <= pending_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin scheduler for one write and two read FIFO ports in front of the
// SDRAM controller; issues fixed-length bursts and owns all address generation.
module sdram_port_arb
  import sdram_port_arb_pkg::*;
#(
  parameter int unsigned BURST      = 256,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned WR_BASE    = 0,
  parameter int unsigned RD0_BASE   = 0,
  parameter int unsigned RD1_BASE   = 0,
  parameter int unsigned FRAME_LEN  = 384000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [10:0]       wr_level,
  input  logic [10:0]       rd0_level,
  input  logic [10:0]       rd1_level,
  input  logic              wr_frame_start,
  input  logic              rd0_frame_start,
  input  logic              rd1_frame_start,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [9:0]        sdram_wr_burst,
  output logic [9:0]        sdram_rd_burst,
  output logic [2:0]        grant,
  output logic              busy
);

  localparam int unsigned CNT_W     = 11;
  localparam logic [10:0] WR_THRESH = 11'(BURST);
  localparam logic [10:0] RD_THRESH = 11'(FIFO_DEPTH - BURST);

  arb_state_e        state_q;
  logic [2:0]        grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_req_q, rd_req_q;
  logic [1:0]        last_q;
  logic [CNT_W-1:0]  ack_cnt_q;

  logic [2:0]        elig, pick, advance;
  logic [ADDR_W-1:0] wr_addr, rd0_addr, rd1_addr, pick_addr;
  logic              xfer_ack;

  always_comb begin
    elig = '0;
    if (sdram_init_done) begin
      elig[PORT_WR]  = (wr_level  >= WR_THRESH);
      elig[PORT_RD0] = (rd0_level <= RD_THRESH);
      elig[PORT_RD1] = (rd1_level <= RD_THRESH);
    end
  end

  assign pick = rr_pick(elig, last_q);

  always_comb begin
    pick_addr = wr_addr;
    if (pick[PORT_RD0]) pick_addr = rd0_addr;
    if (pick[PORT_RD1]) pick_addr = rd1_addr;
  end

  assign xfer_ack = grant_q[PORT_WR] ? sdram_wr_ack : sdram_rd_ack;
  assign advance  = (state_q == ST_DONE) ? grant_q : 3'b000;

  sdram_port_addr #(
    .ADDR_W    (ADDR_W),
    .BASE      (WR_BASE),
    .BURST     (BURST),
    .FRAME_LEN (FRAME_LEN)
  ) u_wr_addr (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (wr_frame_start),
    .granted_i     (grant_q[PORT_WR]),
    .advance_i     (advance[PORT_WR]),
    .addr_o        (wr_addr)
  );

  sdram_port_addr #(
    .ADDR_W    (ADDR_W),
    .BASE      (RD0_BASE),
    .BURST     (BURST),
    .FRAME_LEN (FRAME_LEN)
  ) u_rd0_addr (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (rd0_frame_start),
    .granted_i     (grant_q[PORT_RD0]),
    .advance_i     (advance[PORT_RD0]),
    .addr_o        (rd0_addr)
  );

  sdram_port_addr #(
    .ADDR_W    (ADDR_W),
    .BASE      (RD1_BASE),
    .BURST     (BURST),
    .FRAME_LEN (FRAME_LEN)
  ) u_rd1_addr (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (rd1_frame_start),
    .granted_i     (grant_q[PORT_RD1]),
    .advance_i     (advance[PORT_RD1]),
    .addr_o        (rd1_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      addr_q    <= '0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      last_q    <= PORT_RD1;
      ack_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick != '0) begin
            grant_q  <= pick;
            addr_q   <= pick_addr;
            wr_req_q <= pick[PORT_WR];
            rd_req_q <= ~pick[PORT_WR];
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The edge that samples the first ack also drops the request and counts that ack.
          if ((wr_req_q && sdram_wr_ack) || (rd_req_q && sdram_rd_ack)) begin
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            ack_cnt_q <= CNT_W'(1);
            state_q   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (xfer_ack) begin
            ack_cnt_q <= ack_cnt_q + CNT_W'(1);
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          grant_q <= '0;
          last_q  <= onehot_to_port(grant_q);
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sdram_wr_req   = wr_req_q;
  assign sdram_rd_req   = rd_req_q;
  assign sdram_addr     = addr_q;
  assign grant          = grant_q;
  assign busy           = (state_q != ST_IDLE);
  assign sdram_wr_burst = 10'(BURST);
  assign sdram_rd_burst = 10'(BURST);

`ifndef SYNTHESIS
  ack_count_check : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_DONE) |-> (ack_cnt_q == CNT_W'(BURST)))
    else $error("sdram_port_arb: burst ended with %0d acks", ack_cnt_q);
`endif

endmodule

// File: tb/tb_sdram_port_arb.sv
// Scoreboard bench for sdram_port_arb: expected bursts are queued by the
// stimulus, a monitor pops one per new request; a behavioural controller acks.
module tb_sdram_port_arb;

  localparam int unsigned BURST      = 256;
  localparam int unsigned FIFO_DEPTH = 1024;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned FRAME_LEN  = 1024;
  localparam int unsigned WR_BASE    = 0;
  localparam int unsigned RD0_BASE   = 'h1000;
  localparam int unsigned RD1_BASE   = 'h2000;
  localparam int unsigned BUDGET     = 4000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sdram_init_done = 1'b0;
  logic [10:0]       wr_level = '0, rd0_level = 11'd1000, rd1_level = 11'd1000;
  logic              wr_frame_start = 1'b0, rd0_frame_start = 1'b0, rd1_frame_start = 1'b0;
  logic              sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
  logic              sdram_wr_req, sdram_rd_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic [9:0]        sdram_wr_burst, sdram_rd_burst;
  logic [2:0]        grant;
  logic              busy;

  always #5 clk = ~clk;

  sdram_port_arb #(
    .BURST      (BURST),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W),
    .WR_BASE    (WR_BASE),
    .RD0_BASE   (RD0_BASE),
    .RD1_BASE   (RD1_BASE),
    .FRAME_LEN  (FRAME_LEN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .wr_level        (wr_level),
    .rd0_level       (rd0_level),
    .rd1_level       (rd1_level),
    .wr_frame_start  (wr_frame_start),
    .rd0_frame_start (rd0_frame_start),
    .rd1_frame_start (rd1_frame_start),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_addr      (sdram_addr),
    .sdram_wr_burst  (sdram_wr_burst),
    .sdram_rd_burst  (sdram_rd_burst),
    .grant           (grant),
    .busy            (busy)
  );

  typedef struct packed {
    logic              wr;
    logic [2:0]        grant;
    logic [ADDR_W-1:0] addr;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic wr, input logic [2:0] g, input logic [ADDR_W-1:0] a);
    txn_t t;
    t.wr = wr; t.grant = g; t.addr = a;
    exp_q.push_back(t);
  endtask

  // Monitor: each new request is one burst; compare against the queue head.
  logic prev_req = 1'b0;
  always @(negedge clk) begin : monitor
    logic req_now;
    txn_t e;
    req_now = sdram_wr_req | sdram_rd_req;
    if (rst_n && req_now && !prev_req) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", {30'b0, sdram_wr_req, sdram_rd_req}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("txn_grant",  {29'b0, grant}, {29'b0, e.grant});
        check("txn_addr",   {8'b0, sdram_addr}, {8'b0, e.addr});
        check("txn_wr_req", {31'b0, sdram_wr_req}, {31'b0, e.wr});
        check("txn_rd_req", {31'b0, sdram_rd_req}, {31'b0, ~e.wr});
      end
    end
    prev_req = rst_n ? req_now : 1'b0;
  end

  // Controller model: 3-cycle latency, then BURST ack cycles; aborts on reset.
  initial begin : ctrl_model
    forever begin
      @(posedge clk); #1;
      if (rst_n && (sdram_wr_req || sdram_rd_req)) begin
        logic is_wr;
        is_wr = sdram_wr_req;
        for (int i = 0; i < 3 && rst_n; i++) @(posedge clk);
        #1;
        if (rst_n) begin
          if (is_wr) sdram_wr_ack = 1'b1;
          else       sdram_rd_ack = 1'b1;
          for (int i = 0; i < BURST && rst_n; i++) @(posedge clk);
          #1;
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_grant"},  {29'b0, grant}, 32'h0);
    check({tag, "_wr_req"}, {31'b0, sdram_wr_req}, 32'h0);
    check({tag, "_rd_req"}, {31'b0, sdram_rd_req}, 32'h0);
    check({tag, "_busy"},   {31'b0, busy}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset");
    check("reset_addr",     {8'b0, sdram_addr}, 32'h0);
    check("reset_wr_burst", {22'b0, sdram_wr_burst}, 32'd256);
    check("reset_rd_burst", {22'b0, sdram_rd_burst}, 32'd256);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_q_empty(input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({name, "_timeout"}, exp_q.size(), 32'h0);
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    check({name, "_stays_idle"}, {31'b0, busy}, 32'h0);
  endtask

  task automatic wait_ack(input string name);
    int unsigned n = 0;
    while (!(sdram_wr_ack || sdram_rd_ack) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ack_seen"}, {31'b0, sdram_wr_ack | sdram_rd_ack}, 32'h1);
  endtask

  initial begin : stimulus
    do_reset();

    // Single write, boundary level, then frame wrap.
    sdram_init_done = 1'b1;
    wr_level = 11'd255;
    repeat (20) @(negedge clk);
    check("wr_255_not_eligible", {31'b0, busy}, 32'h0);
    expect_txn(1'b1, 3'b001, 24'd0);
    expect_txn(1'b1, 3'b001, 24'd256);
    expect_txn(1'b1, 3'b001, 24'd512);
    expect_txn(1'b1, 3'b001, 24'd768);
    expect_txn(1'b1, 3'b001, 24'd0);
    wr_level = 11'd256;
    wait_q_empty("wrap");
    wr_level = 11'd0;
    wait_idle("wrap");

    // Round-robin with all ports eligible (reads exactly at threshold).
    do_reset();
    expect_txn(1'b1, 3'b001, 24'h000000);
    expect_txn(1'b0, 3'b010, 24'h001000);
    expect_txn(1'b0, 3'b100, 24'h002000);
    expect_txn(1'b1, 3'b001, 24'h000100);
    expect_txn(1'b0, 3'b010, 24'h001100);
    wr_level = 11'd256; rd0_level = 11'd768; rd1_level = 11'd768;
    wait_q_empty("rr");
    wr_level = 11'd0; rd0_level = 11'd1000; rd1_level = 11'd1000;
    wait_idle("rr");

    // Init gating.
    sdram_init_done = 1'b0;
    do_reset();
    wr_level = 11'd256; rd0_level = 11'd0; rd1_level = 11'd0;
    repeat (30) @(negedge clk);
    check_outputs_zero("init_gate");
    expect_txn(1'b1, 3'b001, 24'd0);
    sdram_init_done = 1'b1;
    wait_q_empty("init");
    wr_level = 11'd0; rd0_level = 11'd1000; rd1_level = 11'd1000;
    wait_idle("init");

    // Frame start during the write burst at 512.
    do_reset();
    expect_txn(1'b1, 3'b001, 24'd0);
    expect_txn(1'b1, 3'b001, 24'd256);
    expect_txn(1'b1, 3'b001, 24'd512);
    wr_level = 11'd256;
    wait_q_empty("fs_pre");
    wait_ack("fs_xfer");
    repeat (10) @(negedge clk);
    expect_txn(1'b1, 3'b001, 24'd0);
    wr_frame_start = 1'b1;
    @(negedge clk);
    wr_frame_start = 1'b0;
    wait_q_empty("fs_rewind");
    wr_level = 11'd0;
    wait_idle("fs_rewind");

    // Frame start on an idle rd1 port.
    expect_txn(1'b0, 3'b100, 24'h002000);
    rd1_level = 11'd0;
    wait_q_empty("rd1_first");
    rd1_level = 11'd1000;
    wait_idle("rd1_first");
    rd1_frame_start = 1'b1;
    @(negedge clk);
    rd1_frame_start = 1'b0;
    repeat (2) @(negedge clk);
    expect_txn(1'b0, 3'b100, 24'h002000);
    rd1_level = 11'd0;
    wait_q_empty("rd1_rewind");
    rd1_level = 11'd1000;
    wait_idle("rd1_rewind");

    // Reset in the middle of the third write burst.
    do_reset();
    expect_txn(1'b1, 3'b001, 24'd0);
    expect_txn(1'b1, 3'b001, 24'd256);
    expect_txn(1'b1, 3'b001, 24'd512);
    wr_level = 11'd256;
    wait_q_empty("rst_pre");
    wait_ack("rst_xfer");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    repeat (3) @(negedge clk);
    expect_txn(1'b1, 3'b001, 24'd0);
    rst_n = 1'b1;
    wait_q_empty("rst_post");
    wr_level = 11'd0;
    wait_idle("rst_post");

    check("leftover_expected", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
